// File: rtl/mem_port_arbiter.sv
// Two-master arbiter (instruction fetch and data) in front of one shared memory port.
// Data normally wins; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;
  logic       fetch_sel;

  // Fetch only takes the port from a competing data request once it has waited its quota.
  assign fetch_sel = i_req && (!d_req || (starve_cnt == STARVE_LIM));

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_comb begin
    if (fetch_sel) begin
      mem_addr  = i_addr;
      mem_we    = 1'b0;
      mem_be    = 4'hF;
      mem_wdata = 32'h0;
    end else begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;

    case (state)
      IDLE: begin
        mem_req = i_req || d_req;
        i_gnt   = fetch_sel && mem_req && mem_gnt;
        d_gnt   = !fetch_sel && d_req && mem_req && mem_gnt;
        if (i_gnt) begin
          state_next  = WAIT_I;
          starve_next = 4'd0;
        end else if (d_gnt) begin
          state_next = WAIT_D;
          if (!i_req) begin
            starve_next = 4'd0;
          end else if (starve_cnt >= STARVE_LIM) begin
            starve_next = STARVE_LIM;
          end else begin
            starve_next = starve_cnt + 4'd1;
          end
        end
      end
      WAIT_I: begin
        i_rvalid = mem_rvalid;
        if (mem_rvalid) begin
          state_next = IDLE;
        end
      end
      WAIT_D: begin
        d_rvalid = mem_rvalid;
        if (mem_rvalid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset gates every handshake output, whatever the state register still holds.
    if (!RSTn) begin
      mem_req  = 1'b0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive data grants while fetch waits; legal range 1..15.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RSTn  in  1  synchronous, active-low reset.
REQ-004 i_req  in  1  fetch request; i_addr  in  32  fetch word address.
REQ-005 i_gnt  out  1  fetch request accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  32  fetch data.
REQ-006 d_req  in  1  data request; d_we  in  1  write when 1; d_addr  in  32  data address; d_wdata  in  32  write data; d_be  in  4  byte enables.
REQ-007 d_gnt  out  1  data request accepted; d_rvalid  out  1  data response (read data or write ack); d_rdata  out  32  read data.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4: single shared memory request port.
REQ-009 mem_gnt  in  1  memory accepts request; mem_rvalid  in  1  response valid, one per accepted request, latency >= 1 cycle; mem_rdata  in  32.

Function
REQ-010 The block SHALL implement FSM states IDLE, WAIT_I, WAIT_D; at most one transaction outstanding.
REQ-011 In IDLE, the block SHALL drive mem_req combinationally from the selected requester: d_req over i_req, except fetch wins when both request and starve_cnt == STARVE_MAX.
REQ-012 When fetch is selected: mem_addr=i_addr, mem_we=0, mem_be=4'hF, mem_wdata=0; when data is selected: mem_* = d_* fields.
REQ-013 i_gnt/d_gnt SHALL equal (selected owner) AND mem_req AND mem_gnt, same cycle, combinational.
REQ-014 On mem_req && mem_gnt, the FSM SHALL move IDLE->WAIT_I or IDLE->WAIT_D at the next edge; with no grant it stays IDLE.
REQ-015 In WAIT_I/WAIT_D, mem_req, i_gnt and d_gnt SHALL be 0.
REQ-016 In WAIT_x, on mem_rvalid the block SHALL assert x_rvalid the same cycle (combinational) and return to IDLE at the next edge; a new request issues no earlier than that next cycle.
REQ-017 i_rdata and d_rdata SHALL be mem_rdata pass-through; only the rvalid of the current owner is asserted.
REQ-018 mem_rvalid in IDLE SHALL be ignored: no rvalid asserted, no state change.
REQ-019 Write requests SHALL complete through the same WAIT_D path; d_rvalid is the write ack.
REQ-020 starve_cnt (4 bit): on a data grant with i_req=1, increment, saturating at STARVE_MAX; on a data grant with i_req=0 or on any fetch grant, clear to 0; otherwise hold.
REQ-021 Requesters SHALL hold req and payload stable until granted; the block does not latch payload (no change required on violation).
REQ-022 Throughput: one transaction per (2 + memory latency) cycles minimum per requester stream; no bubble beyond REQ-016.

Reset
REQ-023 While RSTn=0 at an edge: state <= IDLE, starve_cnt <= 0.
REQ-024 While RSTn=0: mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid SHALL be forced 0 regardless of inputs.
REQ-025 Reset mid-transaction SHALL abandon the outstanding transaction; a late mem_rvalid after reset release is ignored per REQ-018.

Verification
REQ-026 Fetch only: i_req=1, i_addr=32'h00400000, mem_gnt=1, mem_rvalid 2 cycles later with mem_rdata=32'h00000013 -> i_gnt 1 cycle, i_rvalid=1 with i_rdata=32'h00000013, mem_we=0, mem_be=4'hF.
REQ-027 Simultaneous: i_req=d_req=1, starve_cnt=0 -> d_gnt first; fetch granted only after d_rvalid and one IDLE cycle.
REQ-028 Starvation, STARVE_MAX=4: d_req and i_req held high continuously -> exactly 4 data grants, then i_gnt, then data again; starve_cnt returns to 0 after fetch grant.
REQ-029 Write: d_we=1, d_addr=32'h10008000, d_wdata=32'hDEADBEEF, d_be=4'b0011 -> mem_* match exactly; d_rvalid on mem_rvalid; i_rvalid stays 0.
REQ-030 Backpressure: mem_gnt=0 for 3 cycles with d_req=1 -> mem_req=1, d_gnt=0, state IDLE for 3 cycles; grant on 4th cycle.
REQ-031 Reset mid-op: RSTn=0 for one cycle in WAIT_D, then mem_rvalid=1 -> d_rvalid=0, state IDLE, next i_req granted immediately.
